// File: rtl/dac_sample_delay_if.sv
// Sample and delay-configuration bus for dac_sample_delay.
// The cfg_rd_dly readback signal exists only with DAC_SAMPLE_DELAY_READBACK_EN.
interface dac_sample_delay_if #(
  parameter int NCH   = 2,
  parameter int WIDTH = 6,
  parameter int DLY_W = 4,
  parameter int CH_W  = 1
);
  logic [NCH*WIDTH-1:0] din;
  logic                 din_valid;
  logic [NCH*WIDTH-1:0] dout;
  logic                 dout_valid;
  logic                 cfg_wr;
  logic [CH_W-1:0]      cfg_ch;
  logic [DLY_W-1:0]     cfg_dly;
  logic                 aligned;
`ifdef DAC_SAMPLE_DELAY_READBACK_EN
  logic [DLY_W-1:0]     cfg_rd_dly;

  modport master (
    output din, din_valid, cfg_wr, cfg_ch, cfg_dly,
    input  dout, dout_valid, aligned, cfg_rd_dly
  );
  modport slave (
    input  din, din_valid, cfg_wr, cfg_ch, cfg_dly,
    output dout, dout_valid, aligned, cfg_rd_dly
  );
`else
  modport master (
    output din, din_valid, cfg_wr, cfg_ch, cfg_dly,
    input  dout, dout_valid, aligned
  );
  modport slave (
    input  din, din_valid, cfg_wr, cfg_ch, cfg_dly,
    output dout, dout_valid, aligned
  );
`endif
endinterface

// File: rtl/dac_sample_delay.sv
// Per-channel coarse sample delay for the DAC pins (clkcomm domain), IDLE_CODE until filled.
// Optional delay readback port enabled by defining DAC_SAMPLE_DELAY_READBACK_EN.
module dac_sample_delay #(
  parameter int               NCH         = 2,
  parameter int               WIDTH       = 6,
  parameter int               MAX_DLY     = 15,
  parameter int               DLY_W       = 4,
  parameter int               CH_W        = 1,
  parameter int               DEFAULT_DLY = 0,
  parameter logic [WIDTH-1:0] IDLE_CODE   = '0
) (
  input logic               clkcomm,
  input logic               RST,
  dac_sample_delay_if.slave bus
);
  localparam int DEPTH  = MAX_DLY + 1;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FILL_W = $clog2(MAX_DLY + 2);

  localparam logic [DLY_W-1:0]  MAX_DLY_V = DLY_W'(MAX_DLY);
  localparam logic [DLY_W-1:0]  DEF_DLY_V = DLY_W'(DEFAULT_DLY);
  localparam logic [FILL_W-1:0] FILL_SAT  = FILL_W'(MAX_DLY + 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [DLY_W:0]    DEPTH_V   = (DLY_W+1)'(DEPTH);

  logic [WIDTH-1:0]     mem_q [NCH][DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [DLY_W-1:0]     dly_q [NCH];
  logic [DLY_W-1:0]     dly_d [NCH];
  logic [FILL_W-1:0]    fill_q [NCH];
  logic [FILL_W-1:0]    fill_d [NCH];
  logic [NCH*WIDTH-1:0] dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 aligned_q, aligned_d;

  logic [DLY_W-1:0]     clamp_dly;
  logic [NCH-1:0]       cfg_hit;
  logic [NCH-1:0]       run;
  logic [DLY_W:0]       idx_sum [NCH];
  logic [PTR_W-1:0]     rd_idx [NCH];
  logic [WIDTH-1:0]     rd_data [NCH];

  always_comb begin
    clamp_dly    = (bus.cfg_dly > MAX_DLY_V) ? MAX_DLY_V : bus.cfg_dly;
    wr_ptr_d     = wr_ptr_q;
    dout_d       = dout_q;
    aligned_d    = aligned_q;
    dout_valid_d = bus.din_valid;
    cfg_hit      = '0;
    run          = '0;
    if (bus.din_valid) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    for (int unsigned c = 0; c < NCH; c++) begin
      // A write coinciding with a valid sample applies to that sample and counts it as fill 1.
      cfg_hit[c] = bus.cfg_wr && (32'(bus.cfg_ch) == c);
      dly_d[c]   = cfg_hit[c] ? clamp_dly : dly_q[c];
      if (cfg_hit[c]) begin
        fill_d[c] = bus.din_valid ? FILL_W'(1) : '0;
      end else if (bus.din_valid && (fill_q[c] != FILL_SAT)) begin
        fill_d[c] = fill_q[c] + 1'b1;
      end else begin
        fill_d[c] = fill_q[c];
      end
      run[c] = 32'(fill_d[c]) > 32'(dly_d[c]);

      // Modular subtract without a power-of-2 depth; zero delay bypasses the RAM.
      idx_sum[c] = (DLY_W+1)'(wr_ptr_q) + DEPTH_V - {1'b0, dly_d[c]};
      if (idx_sum[c] >= DEPTH_V) begin
        idx_sum[c] = idx_sum[c] - DEPTH_V;
      end
      rd_idx[c]  = PTR_W'(idx_sum[c]);
      rd_data[c] = (dly_d[c] == '0) ? bus.din[c*WIDTH +: WIDTH] : mem_q[c][rd_idx[c]];

      if (bus.din_valid) begin
        dout_d[c*WIDTH +: WIDTH] = run[c] ? rd_data[c] : IDLE_CODE;
      end
    end
    if (bus.din_valid) begin
      aligned_d = &run;
    end
  end

  always_ff @(posedge clkcomm) begin
    if (RST) begin
      wr_ptr_q     <= '0;
      dout_q       <= {NCH{IDLE_CODE}};
      dout_valid_q <= 1'b0;
      aligned_q    <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) begin
        dly_q[c]  <= DEF_DLY_V;
        fill_q[c] <= '0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      aligned_q    <= aligned_d;
      for (int unsigned c = 0; c < NCH; c++) begin
        dly_q[c]  <= dly_d[c];
        fill_q[c] <= fill_d[c];
      end
    end
  end

  always_ff @(posedge clkcomm) begin
    if (!RST && bus.din_valid) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        mem_q[c][wr_ptr_q] <= bus.din[c*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.aligned    = aligned_q;

`ifdef DAC_SAMPLE_DELAY_READBACK_EN
  logic [DLY_W-1:0] rd_dly_q, rd_dly_d;

  always_comb begin
    rd_dly_d = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (32'(bus.cfg_ch) == c) begin
        rd_dly_d = dly_q[c];
      end
    end
  end

  always_ff @(posedge clkcomm) begin
    if (RST) begin
      rd_dly_q <= '0;
    end else begin
      rd_dly_q <= rd_dly_d;
    end
  end

  assign bus.cfg_rd_dly = rd_dly_q;
`endif
endmodule

// File: tb/tb_dac_sample_delay.sv
// Bench for dac_sample_delay: two instances (MAX_DLY 15/DEFAULT 0 and MAX_DLY 9/DEFAULT 2)
// driven in lockstep and compared against a sample-history reference model.
module tb_dac_sample_delay;
  logic        clk;
  logic        rst;
  logic [11:0] din;
  logic        din_valid;
  logic        cfg_wr;
  logic [1:0]  cfg_ch;
  logic [3:0]  cfg_dly;

  int checks = 0;
  int errors = 0;

  int         maxd [2] = '{15, 9};
  int         defd [2] = '{0, 2};
  logic [5:0] idle [2] = '{6'h00, 6'h2A};

  dac_sample_delay_if #(.NCH(2), .WIDTH(6), .DLY_W(4), .CH_W(2)) if0 ();
  dac_sample_delay_if #(.NCH(2), .WIDTH(6), .DLY_W(4), .CH_W(2)) if1 ();

  dac_sample_delay #(
    .NCH(2), .WIDTH(6), .MAX_DLY(15), .DLY_W(4), .CH_W(2), .DEFAULT_DLY(0), .IDLE_CODE(6'h00)
  ) dut0 (.clkcomm(clk), .RST(rst), .bus(if0.slave));

  dac_sample_delay #(
    .NCH(2), .WIDTH(6), .MAX_DLY(9), .DLY_W(4), .CH_W(2), .DEFAULT_DLY(2), .IDLE_CODE(6'h2A)
  ) dut1 (.clkcomm(clk), .RST(rst), .bus(if1.slave));

  assign if0.din = din;  assign if0.din_valid = din_valid;
  assign if0.cfg_wr = cfg_wr; assign if0.cfg_ch = cfg_ch; assign if0.cfg_dly = cfg_dly;
  assign if1.din = din;  assign if1.din_valid = din_valid;
  assign if1.cfg_wr = cfg_wr; assign if1.cfg_ch = cfg_ch; assign if1.cfg_dly = cfg_dly;

  logic [11:0] odout [2];
  logic        ovalid [2];
  logic        oalign [2];
  assign odout[0] = if0.dout; assign ovalid[0] = if0.dout_valid; assign oalign[0] = if0.aligned;
  assign odout[1] = if1.dout; assign ovalid[1] = if1.dout_valid; assign oalign[1] = if1.aligned;
`ifdef DAC_SAMPLE_DELAY_READBACK_EN
  logic [3:0] ordly [2];
  assign ordly[0] = if0.cfg_rd_dly;
  assign ordly[1] = if1.cfg_rd_dly;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: history of accepted input vectors plus per-channel delay/fill bookkeeping.
  logic [11:0] hist [$];
  int          mdly [2][2];
  int          mfill [2][2];
  logic [11:0] mdout [2];
  logic        mvalid [2];
  logic        malign [2];
  logic [3:0]  mrd [2];

  task automatic model_edge();
    logic [11:0] v;
    int ch;
    ch = int'(cfg_ch);
    if (!rst && din_valid) begin
      hist.push_back(din);
      if (hist.size() > 40) void'(hist.pop_front());
    end
    for (int k = 0; k < 2; k++) begin
      mrd[k] = (rst || ch > 1) ? 4'd0 : 4'(mdly[k][ch]);
      if (rst) begin
        for (int c = 0; c < 2; c++) begin
          mdly[k][c]  = defd[k];
          mfill[k][c] = 0;
        end
        mdout[k]  = {idle[k], idle[k]};
        mvalid[k] = 1'b0;
        malign[k] = 1'b0;
      end else begin
        if (cfg_wr && ch < 2) begin
          mdly[k][ch]  = (int'(cfg_dly) > maxd[k]) ? maxd[k] : int'(cfg_dly);
          mfill[k][ch] = 0;
        end
        mvalid[k] = din_valid;
        if (din_valid) begin
          malign[k] = 1'b1;
          for (int c = 0; c < 2; c++) begin
            if (mfill[k][c] < maxd[k] + 1) mfill[k][c]++;
            if (mfill[k][c] > mdly[k][c]) begin
              v = hist[hist.size() - 1 - mdly[k][c]];
              mdout[k][c*6 +: 6] = v[c*6 +: 6];
            end else begin
              mdout[k][c*6 +: 6] = idle[k];
              malign[k] = 1'b0;
            end
          end
        end
      end
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [11:0] d,
                       input logic w, input logic [1:0] ch, input logic [3:0] dl);
    rst = r; din_valid = v; din = d; cfg_wr = w; cfg_ch = ch; cfg_dly = dl;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 12'h0, 0, 0, 0);
    cycle(1, 1, 12'hFFF, 1, 0, 4'd7);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (odout[k] !== {idle[k], idle[k]} || ovalid[k] !== 1'b0 || oalign[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d: got %h/%b/%b want %h/0/0", k, odout[k], ovalid[k], oalign[k],
                 {idle[k], idle[k]});
      end
    end
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, {6'(i), 6'(i)}, 0, 0, 0);
      checks++;
      if (odout[0] !== {6'(i), 6'(i)} || ovalid[0] !== 1'b1 || oalign[0] !== 1'b1) begin
        errors++;
        $display("FAIL ramp i=%0d: got %h/%b/%b want %h/1/1", i, odout[0], ovalid[0], oalign[0],
                 {6'(i), 6'(i)});
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({odout[k], ovalid[k], oalign[k]} !== {mdout[k], mvalid[k], malign[k]}) begin
          errors++;
          $display("FAIL ramp_model dut%0d i=%0d: got %h/%b/%b want %h/%b/%b", k, i,
                   odout[k], ovalid[k], oalign[k], mdout[k], mvalid[k], malign[k]);
        end
      end
    end
  endtask

  task automatic test_fill();
    logic [11:0] want;
    cycle(0, 0, 12'h0, 1, 2'd0, 4'd3);
    for (int j = 0; j < 5; j++) begin
      cycle(0, 1, {6'(10 + j), 6'(10 + j)}, 0, 0, 0);
      want = {6'(10 + j), (j < 3) ? 6'd0 : 6'(10 + j - 3)};
      checks++;
      if (odout[0] !== want || oalign[0] !== (j >= 3)) begin
        errors++;
        $display("FAIL fill j=%0d: got %h/%b want %h/%b", j, odout[0], oalign[0], want, j >= 3);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({odout[k], ovalid[k], oalign[k]} !== {mdout[k], mvalid[k], malign[k]}) begin
          errors++;
          $display("FAIL fill_model dut%0d j=%0d: got %h/%b/%b want %h/%b/%b", k, j,
                   odout[k], ovalid[k], oalign[k], mdout[k], mvalid[k], malign[k]);
        end
      end
    end
  endtask

  task automatic test_max_gaps();
    cycle(0, 0, 12'h0, 1, 2'd1, 4'd15);
    for (int t = 0; t < 60; t++) begin
      cycle(0, (t % 3) != 2, 12'($urandom), 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({odout[k], ovalid[k], oalign[k]} !== {mdout[k], mvalid[k], malign[k]}) begin
          errors++;
          $display("FAIL max_gaps dut%0d t=%0d: got %h/%b/%b want %h/%b/%b", k, t,
                   odout[k], ovalid[k], oalign[k], mdout[k], mvalid[k], malign[k]);
        end
      end
    end
  endtask

  task automatic test_clamp_ignore();
    cycle(0, 0, 12'h0, 1, 2'd0, 4'd15);
    cycle(0, 0, 12'h0, 0, 2'd0, 4'd0);
`ifdef DAC_SAMPLE_DELAY_READBACK_EN
    checks++;
    if (ordly[0] !== 4'd15 || ordly[1] !== 4'd9) begin
      errors++;
      $display("FAIL clamp_readback: got %0d/%0d want 15/9", ordly[0], ordly[1]);
    end
`endif
    cycle(0, 0, 12'h0, 1, 2'd3, 4'd5);
    cycle(0, 0, 12'h0, 0, 2'd3, 4'd0);
`ifdef DAC_SAMPLE_DELAY_READBACK_EN
    cycle(0, 0, 12'h0, 0, 2'd3, 4'd0);
    checks++;
    if (ordly[0] !== 4'd0 || ordly[1] !== 4'd0) begin
      errors++;
      $display("FAIL readback_oob: got %0d/%0d want 0/0", ordly[0], ordly[1]);
    end
`endif
    for (int t = 0; t < 24; t++) begin
      cycle(0, 1, 12'($urandom), 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({odout[k], ovalid[k], oalign[k]} !== {mdout[k], mvalid[k], malign[k]}) begin
          errors++;
          $display("FAIL clamp dut%0d t=%0d: got %h/%b/%b want %h/%b/%b", k, t,
                   odout[k], ovalid[k], oalign[k], mdout[k], mvalid[k], malign[k]);
        end
      end
    end
  endtask

  task automatic test_coincident();
    logic [5:0] want [3] = '{6'd0, 6'd0, 6'd50};
    for (int j = 0; j < 3; j++) begin
      cycle(0, 1, {6'(50 + j), 6'(50 + j)}, j == 0, 2'd0, 4'd2);
      checks++;
      if (odout[0][5:0] !== want[j]) begin
        errors++;
        $display("FAIL coincident j=%0d: got %0d want %0d", j, odout[0][5:0], want[j]);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({odout[k], ovalid[k], oalign[k]} !== {mdout[k], mvalid[k], malign[k]}) begin
          errors++;
          $display("FAIL coincident_model dut%0d j=%0d: got %h/%b/%b want %h/%b/%b", k, j,
                   odout[k], ovalid[k], oalign[k], mdout[k], mvalid[k], malign[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] s [3];
    for (int t = 0; t < 5; t++) cycle(0, 1, 12'($urandom), 0, 0, 0);
    cycle(1, 1, 12'($urandom), 1, 2'd1, 4'd4);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (odout[k] !== {idle[k], idle[k]} || ovalid[k] !== 1'b0 || oalign[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid dut%0d: got %h/%b/%b want %h/0/0", k, odout[k], ovalid[k],
                 oalign[k], {idle[k], idle[k]});
      end
    end
    for (int j = 0; j < 3; j++) begin
      s[j] = 12'($urandom);
      cycle(0, 1, s[j], 0, 0, 0);
      checks++;
      if (odout[1] !== ((j < 2) ? {idle[1], idle[1]} : s[0]) || odout[0] !== s[j]) begin
        errors++;
        $display("FAIL reset_mid_fill j=%0d: got %h/%h want %h/%h", j, odout[0], odout[1], s[j],
                 (j < 2) ? {idle[1], idle[1]} : s[0]);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      cycle($urandom_range(99) == 0, $urandom_range(3) != 0, 12'($urandom),
            $urandom_range(9) == 0, 2'($urandom), 4'($urandom));
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({odout[k], ovalid[k], oalign[k]} !== {mdout[k], mvalid[k], malign[k]}) begin
          errors++;
          $display("FAIL random dut%0d t=%0d: got %h/%b/%b want %h/%b/%b", k, t,
                   odout[k], ovalid[k], oalign[k], mdout[k], mvalid[k], malign[k]);
        end
`ifdef DAC_SAMPLE_DELAY_READBACK_EN
        checks++;
        if (ordly[k] !== mrd[k]) begin
          errors++;
          $display("FAIL random_readback dut%0d t=%0d: got %0d want %0d", k, t, ordly[k], mrd[k]);
        end
`endif
      end
    end
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_dly = '0;
    test_reset();
    test_ramp();
    test_fill();
    test_max_gaps();
    test_clamp_ignore();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
